// File: rtl/mmu_banked.sv
// mmu_banked: data/instruction MMU in front of the byte-lane RAM banks,
// the instruction ROM and a multi-channel I/O port with ack and timeout.

// Single-port byte-lane RAM bank with a synchronous read.
module bram_ssp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wd,
    output logic [7:0]    rd
);
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Enabled lanes write and/or read; disabled lanes keep their last read data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wd;
            rd_q <= mem[addr];
        end
    end

    assign rd = rd_q;
endmodule

module mmu_banked #(
    parameter int RAM_WORDS     = 1024,
    parameter int RAM_WORDS_LOG = 10,
    parameter int IO_CHANNELS   = 4,
    parameter int IO_TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 im_addr,
    output logic [9:0]                  im_addr_out,
    input  logic [31:0]                 im_data,
    output logic [31:0]                 im_do,
    input  logic                        dm_req,
    input  logic                        dm_we,
    input  logic [1:0]                  dm_size,
    input  logic                        is_signed,
    input  logic [31:0]                 dm_addr,
    input  logic [31:0]                 dm_di,
    output logic                        dm_ready,
    output logic                        dm_valid,
    output logic                        dm_fault,
    output logic [31:0]                 dm_do,
    output logic [IO_CHANNELS-1:0]      io_sel,
    output logic [7:0]                  io_addr,
    output logic                        io_en,
    output logic                        io_we,
    output logic [3:0]                  io_be,
    output logic [31:0]                 io_data_write,
    input  logic [32*IO_CHANNELS-1:0]   io_data_read,
    input  logic [IO_CHANNELS-1:0]      io_ack
);
    localparam int CW = $clog2(IO_TIMEOUT + 1);
    localparam int AW = RAM_WORDS_LOG;

    typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_IO_WAIT} state_t;
    typedef enum logic [1:0] {K_RAM, K_SPLIT, K_IO} kind_t;

    state_t           state_q, state_d;
    kind_t            rq_kind_q, rq_kind_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             io_en_q, io_en_d, io_we_q, io_we_d;
    logic [IO_CHANNELS-1:0] io_sel_q, io_sel_d;
    logic [7:0]       io_addr_q, io_addr_d;
    logic [3:0]       io_be_q, io_be_d;
    logic [31:0]      io_wd_q, io_wd_d, io_rd_q, io_rd_d;
    logic [31:0]      beat1_q, beat1_d;
    logic [AW-1:0]    sp_addr_q, sp_addr_d;
    logic [3:0]       sp_mask_q, sp_mask_d;
    logic [31:0]      sp_wd_q, sp_wd_d;
    logic             rq_we_q, rq_we_d, rq_signed_q, rq_signed_d;
    logic [1:0]       rq_size_q, rq_size_d, rq_off_q, rq_off_d;
    logic             dm_valid_q, dm_valid_d, dm_fault_q, dm_fault_d;
    logic [31:0]      im_do_q, im_do_d;

    // request decode
    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic        mis, ram_ok, io_ok, fault;
    logic [7:0]  mask;
    logic [63:0] wsh;
    logic [AW-1:0] word_idx;
    logic [3:0]  ch;

    // bank port
    logic [3:0]  bank_en;
    logic        bank_we;
    logic [AW-1:0] bank_addr;
    logic [31:0] bank_wd, bank_rd;

    logic [31:0] io_rd_mux;
    logic [63:0] win;
    logic [31:0] win_lo, win_hi, ext;

    logic unused_im;
    assign unused_im   = ^{im_addr[31:12], im_addr[1:0]};
    assign im_addr_out = im_addr[11:2];

    for (genvar i = 0; i < 4; i++) begin : g_bank
        bram_ssp #(.DEPTH(RAM_WORDS), .AW(AW)) u_bank (
            .clk  (clk),
            .en   (bank_en[i]),
            .we   (bank_en[i] & bank_we),
            .addr (bank_addr),
            .wd   (bank_wd[8*i +: 8]),
            .rd   (bank_rd[8*i +: 8])
        );
    end

    // Classify the incoming request: lane mask, shifted store data, legality.
    always_comb begin
        off      = dm_addr[1:0];
        nbytes   = 3'd1 << dm_size;
        mis      = ({1'b0, off} + nbytes) > 3'd4;
        mask     = ((8'd1 << nbytes) - 8'd1) << off;
        wsh      = {32'b0, dm_di} << {off, 3'b000};
        word_idx = dm_addr[AW+1:2];
        ch       = dm_addr[11:8];
        // second beat of a split access must still land inside the RAM
        ram_ok   = (dm_addr[31:28] == 4'h1) && (dm_addr[27:AW+2] == '0) &&
                   !(mis && (&word_idx));
        io_ok    = (dm_addr[31:12] == 20'h80000) && (int'(ch) < IO_CHANNELS) && !mis;
        fault    = (dm_size == 2'd3) || !(ram_ok || io_ok);
    end

    // Read data of the selected I/O channel.
    always_comb begin
        io_rd_mux = '0;
        for (int c = 0; c < IO_CHANNELS; c++)
            if (io_sel_q[c]) io_rd_mux = io_rd_mux | io_data_read[32*c +: 32];
    end

    // Access FSM: next state, bank port and response generation.
    always_comb begin
        state_d     = state_q;
        rq_kind_d   = rq_kind_q;
        cnt_d       = cnt_q;
        io_en_d     = io_en_q;
        io_we_d     = io_we_q;
        io_sel_d    = io_sel_q;
        io_addr_d   = io_addr_q;
        io_be_d     = io_be_q;
        io_wd_d     = io_wd_q;
        io_rd_d     = io_rd_q;
        beat1_d     = beat1_q;
        sp_addr_d   = sp_addr_q;
        sp_mask_d   = sp_mask_q;
        sp_wd_d     = sp_wd_q;
        rq_we_d     = rq_we_q;
        rq_signed_d = rq_signed_q;
        rq_size_d   = rq_size_q;
        rq_off_d    = rq_off_q;
        dm_valid_d  = 1'b0;
        dm_fault_d  = 1'b0;
        im_do_d     = im_data;
        bank_en     = 4'b0;
        bank_we     = 1'b0;
        bank_addr   = word_idx;
        bank_wd     = wsh[31:0];
        dm_ready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                dm_ready = 1'b1;
                if (dm_req) begin
                    rq_we_d     = dm_we;
                    rq_signed_d = is_signed;
                    rq_size_d   = dm_size;
                    rq_off_d    = off;
                    if (fault) begin
                        dm_valid_d = 1'b1;
                        dm_fault_d = 1'b1;
                    end else if (io_ok) begin
                        io_en_d   = 1'b1;
                        io_we_d   = dm_we;
                        io_sel_d  = IO_CHANNELS'(1) << ch;
                        io_addr_d = dm_addr[7:0];
                        io_be_d   = mask[3:0];
                        io_wd_d   = wsh[31:0];
                        cnt_d     = '0;
                        rq_kind_d = K_IO;
                        state_d   = S_IO_WAIT;
                    end else begin
                        bank_en = mask[3:0];
                        bank_we = dm_we;
                        if (mis) begin
                            sp_addr_d = word_idx + AW'(1);
                            sp_mask_d = mask[7:4];
                            sp_wd_d   = wsh[63:32];
                            rq_kind_d = K_SPLIT;
                            state_d   = S_SPLIT;
                        end else begin
                            rq_kind_d  = K_RAM;
                            dm_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_SPLIT: begin
                beat1_d    = bank_rd;
                bank_en    = sp_mask_q;
                bank_we    = rq_we_q;
                bank_addr  = sp_addr_q;
                bank_wd    = sp_wd_q;
                dm_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_IO_WAIT: begin
                if (|(io_ack & io_sel_q)) begin
                    io_rd_d    = io_rd_mux;
                    io_en_d    = 1'b0;
                    dm_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
                    io_en_d    = 1'b0;
                    dm_valid_d = 1'b1;
                    dm_fault_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load result: select the beat window, shift down by the byte offset, extend.
    always_comb begin
        win_lo = bank_rd;
        win_hi = 32'b0;
        case (rq_kind_q)
            K_SPLIT: begin win_lo = beat1_q; win_hi = bank_rd; end
            K_IO:    win_lo = io_rd_q;
            default: ;
        endcase
        win = {win_hi, win_lo} >> {rq_off_q, 3'b000};
        case (rq_size_q)
            2'd0:    ext = {{24{rq_signed_q & win[7]}}, win[7:0]};
            2'd1:    ext = {{16{rq_signed_q & win[15]}}, win[15:0]};
            default: ext = win[31:0];
        endcase
        dm_do = (dm_valid_q && !dm_fault_q && !rq_we_q) ? ext : 32'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rq_kind_q   <= K_RAM;
            cnt_q       <= '0;
            io_en_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_sel_q    <= '0;
            io_addr_q   <= '0;
            io_be_q     <= '0;
            io_wd_q     <= '0;
            io_rd_q     <= '0;
            beat1_q     <= '0;
            sp_addr_q   <= '0;
            sp_mask_q   <= '0;
            sp_wd_q     <= '0;
            rq_we_q     <= 1'b0;
            rq_signed_q <= 1'b0;
            rq_size_q   <= '0;
            rq_off_q    <= '0;
            dm_valid_q  <= 1'b0;
            dm_fault_q  <= 1'b0;
            im_do_q     <= 32'h0000_0013;
        end else begin
            state_q     <= state_d;
            rq_kind_q   <= rq_kind_d;
            cnt_q       <= cnt_d;
            io_en_q     <= io_en_d;
            io_we_q     <= io_we_d;
            io_sel_q    <= io_sel_d;
            io_addr_q   <= io_addr_d;
            io_be_q     <= io_be_d;
            io_wd_q     <= io_wd_d;
            io_rd_q     <= io_rd_d;
            beat1_q     <= beat1_d;
            sp_addr_q   <= sp_addr_d;
            sp_mask_q   <= sp_mask_d;
            sp_wd_q     <= sp_wd_d;
            rq_we_q     <= rq_we_d;
            rq_signed_q <= rq_signed_d;
            rq_size_q   <= rq_size_d;
            rq_off_q    <= rq_off_d;
            dm_valid_q  <= dm_valid_d;
            dm_fault_q  <= dm_fault_d;
            im_do_q     <= im_do_d;
        end
    end

    assign im_do         = im_do_q;
    assign dm_valid      = dm_valid_q;
    assign dm_fault      = dm_fault_q;
    assign io_en         = io_en_q;
    assign io_we         = io_we_q;
    assign io_sel        = io_sel_q;
    assign io_addr       = io_addr_q;
    assign io_be         = io_be_q;
    assign io_data_write = io_wd_q;
endmodule

// File: tb/tb_mmu_banked.sv
// Directed bench for mmu_banked: RAM aligned/split, sign extension, I/O
// handshake and timeout, faults, and reset in the middle of an I/O access.
module tb_mmu_banked;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  im_addr = '0;
    logic [9:0]   im_addr_out;
    logic [31:0]  im_data = '0;
    logic [31:0]  im_do;
    logic         dm_req = 1'b0, dm_we = 1'b0, is_signed = 1'b0;
    logic [1:0]   dm_size = '0;
    logic [31:0]  dm_addr = '0, dm_di = '0;
    logic         dm_ready, dm_valid, dm_fault;
    logic [31:0]  dm_do;
    logic [3:0]   io_sel;
    logic [7:0]   io_addr;
    logic         io_en, io_we;
    logic [3:0]   io_be;
    logic [31:0]  io_data_write;
    logic [127:0] io_data_read = '0;
    logic [3:0]   io_ack = '0;

    int checks = 0;
    int errors = 0;

    // fault vectors: we, size, address
    logic        f_we   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  f_size [7] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [31:0] f_addr [7] = '{32'h0000_0010, 32'h8000_0400, 32'h1000_0000,
                                32'h8000_0003, 32'h1000_0FFF, 32'h2000_0000,
                                32'h1000_1000};

    mmu_banked dut (
        .clk(clk), .reset(reset),
        .im_addr(im_addr), .im_addr_out(im_addr_out), .im_data(im_data), .im_do(im_do),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .is_signed(is_signed),
        .dm_addr(dm_addr), .dm_di(dm_di),
        .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_fault(dm_fault), .dm_do(dm_do),
        .io_sel(io_sel), .io_addr(io_addr), .io_en(io_en), .io_we(io_we), .io_be(io_be),
        .io_data_write(io_data_write), .io_data_read(io_data_read), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present one request; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        dm_req = 1'b1; dm_we = we; dm_size = sz; is_signed = sg; dm_addr = a; dm_di = d;
        tick();
        dm_req = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [31:0] exp_do);
        chk({tag, "_valid"}, 32'(dm_valid), 32'd1);
        chk({tag, "_fault"}, 32'(dm_fault), 32'd0);
        chk({tag, "_do"}, dm_do, exp_do);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        im_data = 32'h1234_5678;
        repeat (2) tick();
        chk("rst_im_do", im_do, 32'h0000_0013);
        chk("rst_ready", 32'(dm_ready), 32'd1);
        chk("rst_valid", 32'(dm_valid), 32'd0);
        chk("rst_fault", 32'(dm_fault), 32'd0);
        chk("rst_do", dm_do, 32'd0);
        chk("rst_io_en", 32'(io_en), 32'd0);
        chk("rst_io", {io_sel, io_addr, io_be, 3'b0, io_we, 12'b0}, 32'd0);
        chk("rst_io_wd", io_data_write, 32'd0);
        reset = 1'b0;

        // fetch port
        tick();
        chk("im_do_1", im_do, 32'h1234_5678);
        im_addr = 32'h0000_0ABC;
        im_data = 32'hCAFE_F00D;
        #1;
        chk("im_addr_out", 32'(im_addr_out), 32'h2AF);
        chk("im_do_hold", im_do, 32'h1234_5678);
        tick();
        chk("im_do_2", im_do, 32'hCAFE_F00D);

        // aligned word, back-to-back
        issue(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'hDEAD_BEEF);
        resp("st_w", 32'd0);
        chk("b2b_ready", 32'(dm_ready), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'd0);
        resp("ld_w", 32'hDEAD_BEEF);
        chk("b2b_ready2", 32'(dm_ready), 32'd1);
        tick();
        chk("valid_pulse", 32'(dm_valid), 32'd0);

        // misaligned word
        issue(1'b1, 2'd2, 1'b0, 32'h1000_0003, 32'h1122_3344);
        chk("mis_st_ready", 32'(dm_ready), 32'd0);
        chk("mis_st_early", 32'(dm_valid), 32'd0);
        tick();
        resp("mis_st", 32'd0);
        issue(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'd0);
        resp("ld_b3", 32'h0000_0044);
        issue(1'b0, 2'd0, 1'b0, 32'h1000_0006, 32'd0);
        resp("ld_b6", 32'h0000_0011);
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0003, 32'd0);
        chk("mis_ld_ready", 32'(dm_ready), 32'd0);
        chk("mis_ld_early", 32'(dm_valid), 32'd0);
        tick();
        resp("mis_ld", 32'h1122_3344);

        // sign extension
        issue(1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h0000_8001);
        resp("st_h", 32'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h1000_0002, 32'd0);
        resp("ld_hs", 32'hFFFF_8001);
        issue(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'd0);
        resp("ld_hu", 32'h0000_8001);
        issue(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0);
        resp("ld_bs", 32'hFFFF_FF80);

        // I/O store with ack three cycles after io_en rises
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0205, 32'h0000_00A5);
        chk("io_en_rise", 32'(io_en), 32'd1);
        chk("io_sel", 32'(io_sel), 32'h4);
        chk("io_addr", 32'(io_addr), 32'h05);
        chk("io_be", 32'(io_be), 32'h2);
        chk("io_wd", io_data_write, 32'h0000_A500);
        chk("io_we", 32'(io_we), 32'd1);
        chk("io_ready", 32'(dm_ready), 32'd0);
        io_ack = 4'b0010;                        // wrong channel
        tick();
        chk("io_wrong_ack_en", 32'(io_en), 32'd1);
        chk("io_wrong_ack_v", 32'(dm_valid), 32'd0);
        io_ack = 4'b0000;
        tick();
        chk("io_hold_en", 32'(io_en), 32'd1);
        io_ack = 4'b0100;
        tick();
        io_ack = 4'b0000;
        chk("io_ack_en", 32'(io_en), 32'd0);
        resp("io_st", 32'd0);

        // I/O load with ack in the same cycle io_en rises
        io_data_read[64 +: 32] = 32'h0000_C300;
        issue(1'b0, 2'd0, 1'b0, 32'h8000_0205, 32'd0);
        io_ack = 4'b0100;
        tick();
        io_ack = 4'b0000;
        chk("io_ld_en", 32'(io_en), 32'd0);
        resp("io_ld", 32'h0000_00C3);

        // I/O timeout
        issue(1'b1, 2'd2, 1'b0, 32'h8000_0100, 32'h0000_0055);
        chk("to_sel", 32'(io_sel), 32'h2);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                chk("to_early_valid", 32'(dm_valid), 32'd0);
                chk("to_early_en", 32'(io_en), 32'd1);
            end
        end
        chk("to_valid", 32'(dm_valid), 32'd1);
        chk("to_fault", 32'(dm_fault), 32'd1);
        chk("to_en", 32'(io_en), 32'd0);
        tick();
        chk("to_pulse", 32'(dm_valid), 32'd0);

        // faults
        issue(1'b1, 2'd2, 1'b0, 32'h1000_0FFC, 32'h0102_0304);
        resp("st_top", 32'd0);
        for (int i = 0; i < 7; i++) begin
            issue(f_we[i], f_size[i], 1'b0, f_addr[i], 32'hFFFF_FFFF);
            chk($sformatf("flt%0d_valid", i), 32'(dm_valid), 32'd1);
            chk($sformatf("flt%0d_fault", i), 32'(dm_fault), 32'd1);
            chk($sformatf("flt%0d_io_en", i), 32'(io_en), 32'd0);
            chk($sformatf("flt%0d_do", i), dm_do, 32'd0);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'd0);
        resp("flt_w0", 32'h8001_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0FFC, 32'd0);
        resp("flt_top", 32'h0102_0304);

        // reset in IO_WAIT
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'd0);
        chk("rm_io_en", 32'(io_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_io_en_drop", 32'(io_en), 32'd0);
        chk("rm_io_sel", 32'(io_sel), 32'd0);
        chk("rm_ready", 32'(dm_ready), 32'd1);
        chk("rm_im_do", im_do, 32'h0000_0013);
        repeat (2) tick();
        reset = 1'b0;
        chk("rm_rel_ready", 32'(dm_ready), 32'd1);
        chk("rm_rel_im_do", im_do, 32'h0000_0013);
        tick();
        chk("rm_no_valid", 32'(dm_valid), 32'd0);
        tick();
        chk("rm_no_valid2", 32'(dm_valid), 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'd0);
        resp("rm_w0", 32'h8001_BEEF);
        issue(1'b0, 2'd1, 1'b0, 32'h1000_0004, 32'd0);
        resp("rm_h4", 32'h0000_2233);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
